// File: rtl/counter_seq_pkg.sv
// Shared types and defaults for the retriggerable settling-timer counter.
// One-hot-free action decode keeps the next-state logic readable.
package counter_seq_pkg;

  localparam int unsigned CNTR_DW_DEF  = 3;
  localparam int unsigned CNTR_MAX_DEF = 5;

  typedef enum logic [1:0] {
    ACT_IDLE  = 2'd0,
    ACT_START = 2'd1,
    ACT_COUNT = 2'd2,
    ACT_TERM  = 2'd3
  } cntr_act_e;

  // True when the terminal count is representable in the counter width.
  function automatic bit max_fits(input int unsigned dw, input int unsigned max_v);
    if (dw >= 32) return 1'b1;
    return max_v < (32'd1 << dw);
  endfunction

endpackage

// File: rtl/counter_seq_if.sv
// Control/status bundle between a command sequencer and its settling timer.
// The sequencer owns enable/start; the timer returns count and terminal strobe.
interface counter_seq_if #(
  parameter int unsigned dw = 3
) ();

  logic          enable;
  logic          start_strb;
  logic [dw-1:0] cntr;
  logic          strb;

  modport master (
    output enable,
    output start_strb,
    input  cntr,
    input  strb
  );

  modport slave (
    input  enable,
    input  start_strb,
    output cntr,
    output strb
  );

endinterface

// File: rtl/counter_seq.sv
// Retriggerable settling timer: strb pulses max+1 enabled clocks after the last sampled start.
// No backpressure; enable low freezes all state, including a pending strb.
module counter_seq
  import counter_seq_pkg::*;
#(
  parameter int unsigned dw  = CNTR_DW_DEF,
  parameter int unsigned max = CNTR_MAX_DEF
) (
  input logic          clk,
  input logic          reset,
  counter_seq_if.slave bus
);

  if (!max_fits(dw, max)) begin : g_max_range
    $error("counter_seq: max does not fit in dw bits");
  end

  localparam logic [dw-1:0] MAX_C = dw'(max);
  localparam logic [dw-1:0] ONE_C = dw'(1);

  logic          run_q, run_d;
  logic [dw-1:0] cntr_q, cntr_d;
  logic          strb_q, strb_d;
  logic          terminal;
  cntr_act_e     act;

  assign terminal = run_q && (cntr_q == MAX_C);

  // Start outranks the terminal action, but the terminal strobe still fires.
  always_comb begin
    act = ACT_IDLE;
    if (bus.start_strb) begin
      act = ACT_START;
    end else if (run_q) begin
      act = terminal ? ACT_TERM : ACT_COUNT;
    end
  end

  always_comb begin
    run_d  = run_q;
    cntr_d = cntr_q;
    strb_d = strb_q;
    if (bus.enable) begin
      strb_d = terminal;
      case (act)
        ACT_START: begin
          cntr_d = '0;
          run_d  = 1'b1;
        end
        ACT_COUNT: begin
          cntr_d = cntr_q + ONE_C;
          run_d  = 1'b1;
        end
        ACT_TERM: begin
          cntr_d = '0;
          run_d  = 1'b0;
        end
        default: begin
          cntr_d = '0;
          run_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_q  <= 1'b0;
      cntr_q <= '0;
      strb_q <= 1'b0;
    end else begin
      run_q  <= run_d;
      cntr_q <= cntr_d;
      strb_q <= strb_d;
    end
  end

  assign bus.cntr = cntr_q;
  assign bus.strb = strb_q;

endmodule

// File: tb/tb_counter_seq.sv
// Bench for counter_seq: three instances (max=5, max=0, dw=4/max=15) share one stimulus stream.
module tb_counter_seq;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b0;
  logic start_strb = 1'b0;

  always #5 clk = ~clk;

  counter_seq_if #(.dw(3)) bus_a ();
  counter_seq_if #(.dw(3)) bus_b ();
  counter_seq_if #(.dw(4)) bus_c ();

  assign bus_a.enable = enable;
  assign bus_b.enable = enable;
  assign bus_c.enable = enable;
  assign bus_a.start_strb = start_strb;
  assign bus_b.start_strb = start_strb;
  assign bus_c.start_strb = start_strb;

  counter_seq #(.dw(3), .max(5))  u_a (.clk(clk), .reset(reset), .bus(bus_a));
  counter_seq #(.dw(3), .max(0))  u_b (.clk(clk), .reset(reset), .bus(bus_b));
  counter_seq #(.dw(4), .max(15)) u_c (.clk(clk), .reset(reset), .bus(bus_c));

  logic [3:0] dut_c [3];
  logic       dut_s [3];
  assign dut_c[0] = {1'b0, bus_a.cntr};
  assign dut_c[1] = {1'b0, bus_b.cntr};
  assign dut_c[2] = bus_c.cntr;
  assign dut_s[0] = bus_a.strb;
  assign dut_s[1] = bus_b.strb;
  assign dut_s[2] = bus_c.strb;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input int idx, input int got, input int want);
    n_chk++;
    if (got == want) n_pass++;
    else $display("FAIL %s[%0d] got %0d want %0d", name, idx, got, want);
  endtask

  // Model: age = enabled edges since the last sampled start (IDLE_AGE when none).
  // The count shows age while age <= max; strb fires on the enabled edge leaving age == max.
  localparam int IDLE_AGE = 1000;
  int maxv [3] = '{5, 0, 15};
  int age  [3] = '{IDLE_AGE, IDLE_AGE, IDLE_AGE};
  bit m_strb [3] = '{1'b0, 1'b0, 1'b0};

  function automatic int next_age(input int a, input bit st);
    if (st) return 0;
    if (a >= IDLE_AGE) return IDLE_AGE;
    return a + 1;
  endfunction

  function automatic int exp_cntr(input int a, input int m);
    return (a <= m) ? a : 0;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++) begin
        age[i]    <= IDLE_AGE;
        m_strb[i] <= 1'b0;
      end
    end else if (enable) begin
      for (int i = 0; i < 3; i++) begin
        m_strb[i] <= (age[i] == maxv[i]);
        age[i]    <= next_age(age[i], start_strb);
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      check("model_cntr", i, int'(dut_c[i]), exp_cntr(age[i], maxv[i]));
      check("model_strb", i, int'(dut_s[i]), int'(m_strb[i]));
    end
  end

  // Observe instance A against hand-computed values, then drive the next inputs.
  task automatic step(input bit en, input bit st, input int ec, input int es);
    @(negedge clk);
    check("lit_cntr_a", 0, int'(dut_c[0]), ec);
    check("lit_strb_a", 0, int'(dut_s[0]), es);
    enable     = en;
    start_strb = st;
  endtask

  int fa, fb, fc, na, nb, nc, pc;

  initial begin
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("reset_cntr", i, int'(dut_c[i]), 0);
      check("reset_strb", i, int'(dut_s[i]), 0);
    end
    reset = 1'b1;

    // basic single start
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    for (int k = 1; k <= 5; k++) step(1, 0, k, 0);
    step(1, 0, 0, 1);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);

    // retrigger at cntr=3
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 1, 0);
    step(1, 0, 2, 0);
    step(1, 1, 3, 0);
    step(1, 0, 0, 0);
    for (int k = 1; k <= 5; k++) step(1, 0, k, 0);
    step(1, 0, 0, 1);
    step(1, 0, 0, 0);

    // start coinciding with the terminal edge
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    for (int k = 1; k <= 4; k++) step(1, 0, k, 0);
    step(1, 1, 5, 0);
    step(1, 0, 0, 1);
    for (int k = 1; k <= 5; k++) step(1, 0, k, 0);
    step(1, 0, 0, 1);
    step(1, 0, 0, 0);

    // enable freeze at cntr=2, then freeze a pending strb
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 1, 0);
    step(0, 0, 2, 0);
    step(0, 0, 2, 0);
    step(0, 0, 2, 0);
    step(0, 0, 2, 0);
    step(1, 0, 2, 0);
    step(1, 0, 3, 0);
    step(1, 0, 4, 0);
    step(1, 0, 5, 0);
    step(0, 0, 0, 1);
    step(1, 0, 0, 1);
    step(1, 0, 0, 0);

    // multi-cycle start holds the count at 0
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    for (int k = 1; k <= 5; k++) step(1, 0, k, 0);
    step(1, 0, 0, 1);
    step(1, 0, 0, 0);

    // asynchronous reset mid-count
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 1, 0);
    step(1, 0, 2, 0);
    step(1, 0, 3, 0);
    #2 reset = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("async_rst_cntr", i, int'(dut_c[i]), 0);
      check("async_rst_strb", i, int'(dut_s[i]), 0);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 18; k++) step(1, 0, 0, 0);

    // strobe latency across parameterisations
    step(1, 1, 0, 0);
    fa = -1; fb = -1; fc = -1; na = 0; nb = 0; nc = 0; pc = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (dut_s[0]) begin na++; if (fa < 0) fa = i; end
      if (dut_s[1]) begin nb++; if (fb < 0) fb = i; end
      if (dut_s[2]) begin nc++; if (fc < 0) fc = i; end
      if (int'(dut_c[2]) > pc) pc = int'(dut_c[2]);
      start_strb = 1'b0;
    end
    check("lat_a", 0, fa, 7);
    check("lat_b", 1, fb, 2);
    check("lat_c", 2, fc, 17);
    check("nstrb_a", 0, na, 1);
    check("nstrb_b", 1, nb, 1);
    check("nstrb_c", 2, nc, 1);
    check("peak_c", 2, pc, 15);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
